// File: rtl/serial_subtractor_if.sv
// Start/done handshake bundle for serial_subtractor.
// Defining SERIAL_SUBTRACTOR_OVF_EN adds the signed-overflow flag ovf.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic             ovf;

    modport master (output start, a, b, bin, input busy, done, diff, borrow, ovf);
    modport slave  (input start, a, b, bin, output busy, done, diff, borrow, ovf);
`else
    modport master (output start, a, b, bin, input busy, done, diff, borrow);
    modport slave  (input start, a, b, bin, output busy, done, diff, borrow);
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, CHUNK bits per cycle, LSB chunk first.
// Optional SERIAL_SUBTRACTOR_OVF_EN adds a registered signed-overflow output.
module serial_subtractor #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input logic                clk,
    input logic                reset,
    serial_subtractor_if.slave bus
);
    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned SUB_W  = CHUNK + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               brw_q, brw_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               borrow_q, borrow_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic               ovf_q, ovf_d;
`endif

    logic [CHUNK-1:0]   a_c;
    logic [CHUNK-1:0]   b_c;
    logic [SUB_W-1:0]   sub;
    logic               last;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            brw_q    <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            brw_q    <= brw_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    // Operands shift right so the active chunk always sits in the low bits
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        brw_d    = brw_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ovf_d    = ovf_q;
`endif
        a_c  = a_q[CHUNK-1:0];
        b_c  = b_q[CHUNK-1:0];
        sub  = {1'b0, a_c} - {1'b0, b_c} - SUB_W'(brw_q);
        last = (cnt_q == CNT_W'(NCHUNK - 1));

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    a_d     = bus.a;
                    b_d     = bus.b;
                    brw_d   = bus.bin;
                    cnt_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                diff_d[int'(cnt_q) * CHUNK +: CHUNK] = sub[CHUNK-1:0];
                a_d   = a_q >> CHUNK;
                b_d   = b_q >> CHUNK;
                brw_d = sub[CHUNK];
                cnt_d = cnt_q + CNT_W'(1);
                if (last) begin
                    state_d  = DONE;
                    done_d   = 1'b1;
                    borrow_d = sub[CHUNK];
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                    // Final chunk's top bits are the operand and result sign bits
                    ovf_d    = (a_c[CHUNK-1] != b_c[CHUNK-1]) &&
                               (sub[CHUNK-1] != a_c[CHUNK-1]);
`endif
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.diff   = diff_q;
    assign bus.borrow = borrow_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    assign bus.ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: random and directed operations vs an arithmetic model.
module tb_serial_subtractor;
    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] d;
        logic         brw;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_done = 0;
    int   cyc    = 0;
    exp_t exp_q[$];
    int   done_stamp[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W), .CHUNK(8)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        exp_t        e;
        logic [W:0]  full;
        longint      sr;
        full  = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
        sr    = longint'($signed(a)) - longint'($signed(b)) - longint'(bin);
        e.d   = full[W-1:0];
        e.brw = full[W];
        e.ovf = (sr > 64'sh7FFF_FFFF) || (sr < -64'sh8000_0000);
        return e;
    endfunction

    task automatic chk(input string name, input logic ok, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    endtask

    // Monitor: every done pulse consumes one expected result
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.done) begin
            n_done++;
            done_stamp.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_chk++;
                $display("FAIL spurious_done: actual=done required=no_done (t=%0t)", $time);
            end else begin
                e = exp_q.pop_front();
                chk("diff", bus.diff == e.d, 64'(bus.diff), 64'(e.d));
                chk("borrow", bus.borrow == e.brw, 64'(bus.borrow), 64'(e.brw));
                chk("busy_in_done", bus.busy == 1'b0, 64'(bus.busy), 64'd0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                chk("ovf", bus.ovf == e.ovf, 64'(bus.ovf), 64'(e.ovf));
`endif
            end
        end
    end

    task automatic wait_not_busy();
        for (int i = 0; i < 20 && bus.busy; i++) @(negedge clk);
        if (bus.busy) chk("idle_timeout", 1'b0, 64'd1, 64'd0);
    endtask

    task automatic wait_quiet();
        for (int i = 0; i < 20 && (bus.busy || bus.done); i++) @(negedge clk);
        if (bus.busy || bus.done) chk("quiet_timeout", 1'b0, 64'd1, 64'd0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        chk("drain", exp_q.size() == 0, 64'(exp_q.size()), 64'd0);
    endtask

    // Issue one operation; returns at the negedge after the accepting edge
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        wait_not_busy();
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.bin   = bin;
        @(posedge clk);
        exp_q.push_back(model(a, b, bin));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    initial begin
        int            lat;
        int            bcnt;
        logic          got;
        int            n0;
        int            s0;
        logic [W-1:0]  edge_tab[4];
        logic [W-1:0]  ra;
        logic [W-1:0]  rb;

        edge_tab[0] = 32'h0000_0000;
        edge_tab[1] = 32'hFFFF_FFFF;
        edge_tab[2] = 32'h8000_0000;
        edge_tab[3] = 32'h7FFF_FFFF;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy == 1'b0, 64'(bus.busy), 64'd0);
        chk("rst_done", bus.done == 1'b0, 64'(bus.done), 64'd0);
        chk("rst_diff", bus.diff == '0, 64'(bus.diff), 64'd0);
        chk("rst_borrow", bus.borrow == 1'b0, 64'(bus.borrow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Inverse of the adder: latency and busy width
        do_op(32'd580, 32'd456, 1'b1);
        lat  = 1;
        bcnt = 0;
        got  = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            if (bus.busy) bcnt++;
            if (bus.done) got = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        chk("latency", got && lat == 5, 64'(lat), 64'd5);
        chk("busy_cycles", bcnt == 4, 64'(bcnt), 64'd4);
        chk("diff_value_123", bus.diff == 32'd123, 64'(bus.diff), 64'd123);

        do_op(32'd0, 32'd1, 1'b0);
        do_op(32'h0000_0100, 32'h0000_0001, 1'b0);
        do_op(32'h8000_0000, 32'd1, 1'b0);
        do_op(32'd5, 32'd3, 1'b0);
        drain();

        // Start during RUN must be ignored
        n0 = n_done;
        do_op(32'd580, 32'd456, 1'b1);
        bus.start = 1'b1;
        bus.a     = 32'hDEAD_BEEF;
        bus.b     = 32'h1234_5678;
        bus.bin   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        drain();
        wait_quiet();
        repeat (3) @(negedge clk);
        chk("ignored_start_done_cnt", n_done - n0 == 1, 64'(n_done - n0), 64'd1);

        // Start held high: back-to-back results every 5 cycles
        wait_quiet();
        n0 = n_done;
        s0 = done_stamp.size();
        bus.start = 1'b1;
        bus.a     = 32'd10;
        bus.b     = 32'd3;
        bus.bin   = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            if (i % 5 == 0) exp_q.push_back(model(32'd10, 32'd3, 1'b0));
        end
        @(negedge clk);
        bus.start = 1'b0;
        drain();
        wait_quiet();
        chk("b2b_done_cnt", n_done - n0 == 3, 64'(n_done - n0), 64'd3);
        if (done_stamp.size() >= s0 + 3) begin
            chk("b2b_gap1", done_stamp[s0+1] - done_stamp[s0] == 5,
                64'(done_stamp[s0+1] - done_stamp[s0]), 64'd5);
            chk("b2b_gap2", done_stamp[s0+2] - done_stamp[s0+1] == 5,
                64'(done_stamp[s0+2] - done_stamp[s0+1]), 64'd5);
        end

        // Reset asserted mid-RUN aborts with no done
        do_op($urandom, $urandom, 1'($urandom_range(0, 1)));
        @(negedge clk);
        #2 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("abort_busy", bus.busy == 1'b0, 64'(bus.busy), 64'd0);
        chk("abort_done", bus.done == 1'b0, 64'(bus.done), 64'd0);
        chk("abort_diff", bus.diff == '0, 64'(bus.diff), 64'd0);
        chk("abort_borrow", bus.borrow == 1'b0, 64'(bus.borrow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        n0 = n_done;
        repeat (10) @(negedge clk);
        chk("abort_no_done", n_done == n0, 64'(n_done - n0), 64'd0);

        // Random operations with random gaps, including back-to-back issue
        for (int k = 0; k < 40; k++) begin
            ra = ($urandom_range(0, 3) == 0) ? edge_tab[$urandom_range(0, 3)] : W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? edge_tab[$urandom_range(0, 3)] : W'($urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_op(ra, rb, 1'($urandom_range(0, 1)));
        end
        drain();
        wait_quiet();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1);
    end
endmodule
